// File: rtl/fpu_rec_pkg.sv
// Shared constants for the recoded floating-point units: rounding modes,
// flag positions, recoded exponent offset and the canonical quiet NaN.
package fpu_rec_pkg;

    localparam int FP_BITS     = 32;
    localparam int EXP_BITS    = 8;
    localparam int FRA_BITS    = 23;
    localparam int SIG_BITS    = 32;
    localparam int RECEXP_BITS = 9;

    localparam logic [RECEXP_BITS-1:0] EXP_OFFSET = 9'h101;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Bit positions inside the {NV,OF,UF,NX} flag vector.
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [FP_BITS-1:0] CANON_NAN      = 32'h7FC0_0000;
    localparam logic [FP_BITS-2:0] MAX_FINITE_MAG = 31'h7F7F_FFFF;

    // Shifting a 32-bit sig right by 26 already pushes the hidden bit below
    // the guard position, so larger denormalising shifts change nothing.
    localparam int SH_CLAMP = 26;

    // Everything stage 2 needs to finish one beat.
    typedef struct packed {
        logic                special;
        logic [FP_BITS-1:0]  spec_fp;
        logic [3:0]          spec_flags;
        logic                sign;
        logic [EXP_BITS-1:0] pexp;
        logic [FRA_BITS-1:0] frac;
        logic                inc;
        logic                nx;
        logic                tiny;
        logic [2:0]          rm;
    } s1_t;

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision from sign, result lsb, guard and sticky bits.
// Undefined rounding-mode encodings fall back to round-to-nearest-even.
module fp_round_inc
    import fpu_rec_pkg::*;
(
    input  logic [2:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    output logic       inc
);

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RNE:  inc = guard & (sticky | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & (guard | sticky);
            RM_RUP:  inc = ~sign & (guard | sticky);
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fromrec_fn_pipe.sv
// Two-stage recoded-to-IEEE-754 single converter with valid/ready backpressure.
// Define FROMREC_CANON_NAN_EN to emit the canonical quiet NaN for every NaN input.
module fromrec_fn_pipe
    import fpu_rec_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [RECEXP_BITS-1:0] in_exp,
    input  logic [SIG_BITS-1:0]    in_sig,
    input  logic                   in_is_nan,
    input  logic                   in_is_inf,
    input  logic                   in_is_zero,
    input  logic [2:0]             in_rm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FP_BITS-1:0]     out_fp,
    output logic [3:0]             out_flags
);

    logic               s1_valid_reg;
    logic               s2_valid_reg;
    s1_t                s1_reg;
    s1_t                s1_next;
    logic [FP_BITS-1:0] out_fp_reg;
    logic [FP_BITS-1:0] fp_next;
    logic [3:0]         out_flags_reg;
    logic [3:0]         flags_next;

    logic s2_load;
    logic s1_load;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    assign out_valid = s2_valid_reg;
    assign out_fp    = out_fp_reg;
    assign out_flags = out_flags_reg;

    // ---------------- stage 1: denormalise and decide the round increment
    logic signed [9:0]   e_val;
    logic                tiny;
    logic [9:0]          sh_full;
    logic [4:0]          sh;
    logic [63:0]         sig_wide;
    logic                lost;
    logic [FRA_BITS-1:0] frac;
    logic                lsb;
    logic                guard;
    logic                sticky;
    logic                inc;
    logic [FP_BITS-1:0]  nan_fp;
    logic                unused_bits;

    assign e_val   = $signed({1'b0, in_exp}) - $signed({1'b0, EXP_OFFSET});
    assign tiny    = (e_val < 10'sd1);
    assign sh_full = 10'd1 - e_val;
    assign sh      = (sh_full > 10'(SH_CLAMP)) ? 5'(SH_CLAMP) : sh_full[4:0];

    // The low half of the wide shift catches every bit shifted past the sig.
    assign sig_wide = {in_sig, 32'h0} >> sh;
    assign lost     = |sig_wide[31:0];

    always_comb begin
        if (tiny) begin
            frac   = sig_wide[62:40];
            guard  = sig_wide[39];
            sticky = (|sig_wide[38:32]) | lost;
        end else begin
            frac   = in_sig[30:8];
            guard  = in_sig[7];
            sticky = |in_sig[6:0];
        end
    end

    assign lsb = frac[0];

    fp_round_inc u_round_inc (
        .rm     (in_rm),
        .sign   (in_sign),
        .lsb    (lsb),
        .guard  (guard),
        .sticky (sticky),
        .inc    (inc)
    );

`ifdef FROMREC_CANON_NAN_EN
    assign nan_fp = CANON_NAN;
`else
    // Keep the payload, force the quiet bit (CANON_NAN[30:22] is 8'hFF then 1).
    assign nan_fp = {in_sign, CANON_NAN[30:22], in_sig[29:8]};
`endif

    // The hidden bit is assumed set and the wide shift's top bit is always 0.
    assign unused_bits = ^{in_sig[31], sig_wide[63]};

    always_comb begin
        s1_next      = '0;
        s1_next.sign = in_sign;
        s1_next.pexp = tiny ? '0 : e_val[EXP_BITS-1:0];
        s1_next.frac = frac;
        s1_next.inc  = inc;
        s1_next.nx   = guard | sticky;
        s1_next.tiny = tiny;
        s1_next.rm   = in_rm;
        if (in_is_nan) begin
            s1_next.special             = 1'b1;
            s1_next.spec_fp             = nan_fp;
            s1_next.spec_flags[FLAG_NV] = ~in_sig[30];
        end else if (in_is_inf) begin
            s1_next.special = 1'b1;
            s1_next.spec_fp = {in_sign, 8'hFF, 23'h0};
        end else if (in_is_zero) begin
            s1_next.special = 1'b1;
            s1_next.spec_fp = {in_sign, 31'h0};
        end
    end

    // ---------------- stage 2: apply the increment, detect overflow
    logic [FP_BITS-1:0] word;
    logic               ovf;
    logic               give_max;

    // A carry out of the fraction bumps the exponent: subnormal to min-normal,
    // max-finite to infinity.
    assign word = {s1_reg.sign, s1_reg.pexp, s1_reg.frac} + FP_BITS'(s1_reg.inc);
    assign ovf  = (word[30:23] == 8'hFF);

    assign give_max = (s1_reg.rm == RM_RTZ)
                   || ((s1_reg.rm == RM_RDN) && !s1_reg.sign)
                   || ((s1_reg.rm == RM_RUP) &&  s1_reg.sign);

    always_comb begin
        fp_next    = word;
        flags_next = '0;
        if (s1_reg.special) begin
            fp_next    = s1_reg.spec_fp;
            flags_next = s1_reg.spec_flags;
        end else begin
            flags_next[FLAG_OF] = ovf;
            flags_next[FLAG_NX] = s1_reg.nx | ovf;
            flags_next[FLAG_UF] = s1_reg.tiny & s1_reg.nx;
            if (ovf) begin
                fp_next = give_max ? {s1_reg.sign, MAX_FINITE_MAG}
                                   : {s1_reg.sign, 8'hFF, 23'h0};
            end
        end
    end

    // ---------------- pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s1_reg        <= '0;
            out_fp_reg    <= '0;
            out_flags_reg <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_reg <= s1_next;
                end
            end
            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_fp_reg    <= fp_next;
                    out_flags_reg <= flags_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fromrec_fn_pipe.sv
// Self-checking bench for fromrec_fn_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_fromrec_fn_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [31:0] in_sig;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fp;
    logic [3:0]  out_flags;

    fromrec_fn_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sig     (in_sig),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .in_rm      (in_rm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fp     (out_fp),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] fp;
        logic [3:0]  fl;
        int          acc;
    } ent_t;

    ent_t        expq[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    bit          dir_mode = 0;
    logic [31:0] dir_fp;
    logic [3:0]  dir_fl;

`ifdef FROMREC_CANON_NAN_EN
    localparam logic [31:0] NAN_A_EXP = 32'h7FC0_0000;
`else
    localparam logic [31:0] NAN_A_EXP = 32'h7FE0_0000;
`endif

    // Reference: quantise the exact value sig * 2^(E-127-31) to the target ulp
    // (2^(max(E,1)-150)) with integer division, then round by exact remainder.
    function automatic logic [35:0] ref_model(input logic s, input logic [8:0] ex,
                                              input logic [31:0] sg, input logic nan,
                                              input logic inf, input logic zero,
                                              input logic [2:0] rm);
        logic [31:0] fp;
        logic [3:0]  fl;
        logic [30:0] mag;
        int e, eb, sh;
        longint unsigned q, rem, half, enc;
        bit up, nx, of;
        fp = '0;
        fl = '0;
        if (nan) begin
            fl[3] = ~sg[30];
`ifdef FROMREC_CANON_NAN_EN
            fp = 32'h7FC0_0000;
`else
            fp = {s, 8'hFF, 1'b1, sg[29:8]};
`endif
        end else if (inf) begin
            fp = {s, 8'hFF, 23'h0};
        end else if (zero) begin
            fp = {s, 31'h0};
        end else begin
            e  = int'(ex) - 257;
            eb = (e < 1) ? 1 : e;
            sh = 8 + eb - e;
            if (sh >= 40) begin
                q    = 0;
                rem  = {32'h0, sg};
                half = 64'h1 << 40;
            end else begin
                q    = {32'h0, sg} >> sh;
                rem  = {32'h0, sg} - (q << sh);
                half = 64'h1 << (sh - 1);
            end
            case (rm)
                3'd1:    up = 1'b0;
                3'd2:    up = s && (rem != 0);
                3'd3:    up = !s && (rem != 0);
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || ((rem == half) && q[0]);
            endcase
            q   = q + longint'(up);
            enc = (longint'(eb - 1) << 23) + q;
            nx  = (rem != 0);
            of  = (enc >= 64'h7F80_0000);
            if (of) begin
                nx  = 1'b1;
                mag = ((rm == 3'd1) || ((rm == 3'd2) && !s) || ((rm == 3'd3) && s))
                      ? 31'h7F7F_FFFF : 31'h7F80_0000;
            end else begin
                mag = enc[30:0];
            end
            fp = {s, mag};
            fl = {1'b0, of, (e < 1) && nx, nx};
        end
        return {fl, fp};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        assert (got === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    // One clock: check outputs at the falling edge, record handshakes, advance.
    task automatic step(output bit acc);
        ent_t ent;
        bit   exp_ov, exp_ir;
        @(negedge clk);
        exp_ov = (expq.size() > 0) && (cyc >= expq[0].acc + 1);
        exp_ir = (expq.size() < 2) || out_ready;
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        if (exp_ov && out_valid) begin
            chk("out_fp", out_fp, expq[0].fp);
            chk("out_flags", 32'(out_flags), 32'(expq[0].fl));
        end
        if (exp_ov && out_ready) void'(expq.pop_front());
        acc = in_valid && exp_ir && !rst;
        if (acc) begin
            if (dir_mode) begin
                ent.fp = dir_fp;
                ent.fl = dir_fl;
            end else begin
                {ent.fl, ent.fp} = ref_model(in_sign, in_exp, in_sig, in_is_nan,
                                             in_is_inf, in_is_zero, in_rm);
            end
            ent.acc = cyc + 1;
            expq.push_back(ent);
            $display("beat accepted cyc=%0d sign=%0d exp=%h sig=%h cls=%0d%0d%0d rm=%0d -> exp %h/%h",
                     cyc, in_sign, in_exp, in_sig, in_is_nan, in_is_inf, in_is_zero, in_rm,
                     ent.fp, ent.fl);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 20 && expq.size() > 0; i++) step(a);
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    task automatic set_beat(input logic s, input logic [8:0] ex, input logic [31:0] sg,
                            input logic [1:0] cls, input logic [2:0] rm);
        in_sign    = s;
        in_exp     = ex;
        in_sig     = sg;
        in_is_nan  = (cls == 2'd1);
        in_is_inf  = (cls == 2'd2);
        in_is_zero = (cls == 2'd3);
        in_rm      = rm;
    endtask

    // cls: 0 finite, 1 nan, 2 inf, 3 zero
    task automatic send_dir(input logic s, input logic [8:0] ex, input logic [31:0] sg,
                            input logic [1:0] cls, input logic [2:0] rm,
                            input logic [31:0] efp, input logic [3:0] efl);
        bit a;
        a = 1'b0;
        set_beat(s, ex, sg, cls, rm);
        dir_mode = 1'b1;
        dir_fp   = efp;
        dir_fl   = efl;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !a; i++) step(a);
        chk("accept_timeout", 32'(a), 32'd1);
        in_valid = 1'b0;
        dir_mode = 1'b0;
        drain();
    endtask

    initial begin
        bit a;
        int idx, cnt, sent;
        bit have;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_beat(1'b0, 9'h0, 32'h0, 2'd0, 3'd0);

        // reset state
        step(a);
        step(a);
        chk("rst_out_fp", out_fp, 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        rst = 1'b0;
        step(a);

        // directed corners: {NV,OF,UF,NX}
        send_dir(1'b0, 9'h180, 32'h8000_0000, 2'd0, 3'd0, 32'h3F80_0000, 4'b0000);
        send_dir(1'b0, 9'h180, 32'h8000_0080, 2'd0, 3'd0, 32'h3F80_0000, 4'b0001);
        send_dir(1'b0, 9'h180, 32'h8000_0080, 2'd0, 3'd3, 32'h3F80_0001, 4'b0001);
        send_dir(1'b0, 9'h180, 32'h8000_0080, 2'd0, 3'd4, 32'h3F80_0001, 4'b0001);
        send_dir(1'b0, 9'h180, 32'h8000_0180, 2'd0, 3'd0, 32'h3F80_0002, 4'b0001);
        send_dir(1'b0, 9'h180, 32'h8000_0180, 2'd0, 3'd7, 32'h3F80_0002, 4'b0001);
        send_dir(1'b0, 9'h101, 32'h8000_0000, 2'd0, 3'd0, 32'h0040_0000, 4'b0000);
        send_dir(1'b0, 9'h0F0, 32'h8000_0000, 2'd0, 3'd0, 32'h0000_0020, 4'b0000);
        send_dir(1'b0, 9'h0E3, 32'h8000_0000, 2'd0, 3'd0, 32'h0000_0000, 4'b0011);
        send_dir(1'b0, 9'h0E3, 32'h8000_0000, 2'd0, 3'd3, 32'h0000_0001, 4'b0011);
        send_dir(1'b0, 9'h101, 32'hFFFF_FFFF, 2'd0, 3'd0, 32'h0080_0000, 4'b0011);
        send_dir(1'b0, 9'h1FF, 32'hFFFF_FF80, 2'd0, 3'd0, 32'h7F80_0000, 4'b0101);
        send_dir(1'b0, 9'h1FF, 32'hFFFF_FF80, 2'd0, 3'd1, 32'h7F7F_FFFF, 4'b0001);
        send_dir(1'b1, 9'h1FF, 32'hFFFF_FF80, 2'd0, 3'd2, 32'hFF80_0000, 4'b0101);
        send_dir(1'b0, 9'h1FF, 32'hA000_0000, 2'd1, 3'd0, NAN_A_EXP,     4'b1000);
        send_dir(1'b1, 9'h123, 32'h8000_0000, 2'd2, 3'd0, 32'hFF80_0000, 4'b0000);
        send_dir(1'b0, 9'h123, 32'h8000_0000, 2'd3, 3'd0, 32'h0000_0000, 4'b0000);

        // backpressure: 3 beats offered while the consumer stalls 4 cycles
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = (idx < 3);
            set_beat(1'b0, 9'(9'h180 + 16 * idx), 32'h8000_0000 + 32'(idx << 9), 2'd0, 3'd0);
            step(a);
            if (a) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            in_valid = 1'b1;
            set_beat(1'b0, 9'(9'h180 + 16 * idx), 32'h8000_0000 + 32'(idx << 9), 2'd0, 3'd0);
            step(a);
            if (a) idx++;
        end
        in_valid = 1'b0;
        chk("stall_all_sent", 32'(idx), 32'd3);
        drain();

        // reset with two beats in flight
        out_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6 && cnt < 2; i++) begin
            in_valid = 1'b1;
            set_beat(1'b1, 9'(9'h170 + cnt), 32'hC000_0000, 2'd0, 3'd0);
            step(a);
            if (a) cnt++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        expq.delete();
        step(a);
        chk("midrst_out_fp", out_fp, 32'h0);
        step(a);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(a);

        // randomized traffic with random valid/ready
        sent = 0;
        have = 1'b0;
        for (int i = 0; i < 3000 && sent < 300; i++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                logic [31:0] sg;
                int cls;
                cls = $urandom_range(0, 15);
                sg  = $urandom | 32'h8000_0000;
                if ($urandom_range(0, 7) == 0) sg[7:0] = 8'h80;
                in_sign    = 1'($urandom);
                in_exp     = ($urandom_range(0, 3) == 0) ? 9'(9'h1F8 + $urandom_range(0, 7))
                                                         : 9'($urandom);
                in_sig     = sg;
                in_is_nan  = (cls == 0) || (cls == 3);
                in_is_inf  = (cls == 1) || (cls == 3) || (cls == 4);
                in_is_zero = (cls == 2) || (cls == 4);
                in_rm      = 3'($urandom_range(0, 7));
                have = 1'b1;
            end
            in_valid  = have;
            out_ready = ($urandom_range(0, 3) != 0);
            step(a);
            if (a) begin
                have = 1'b0;
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_sent", 32'(sent), 32'd300);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
